// File: rtl/dbus_mtimer_target.sv
// dbus_mtimer_target: DBus responder holding a 64-bit machine timer
// (MTIME/MTIMECMP) with a CTRL/STATUS pair and a registered level interrupt.
// Optional feature macro: DBUS_MTIMER_PRESCALER_EN enables the CTRL.PRESCALE
// tick divider. Without it, the timer ticks every cycle while EN is set.
//
// Bus protocol: there is no ready. A read or a write is a single-cycle request
// that is always accepted. Read data appears on o_DBus_ReadData in the cycle
// after the request and is zero in every other cycle, so several targets can
// be OR-combined onto one return bus.
module dbus_mtimer_target #(
  parameter logic [31:0] p_BASE_ADDR      = 32'h0200_0000,
  parameter logic [7:0]  p_PRESCALE_RESET = 8'd0
) (
  input  logic        i_Clk,
  input  logic        i_Rst,
  input  logic [29:0] i_DBus_Address,
  input  logic [3:0]  i_DBus_ByteEn,
  input  logic        i_DBus_Read,
  input  logic        i_DBus_Write,
  input  logic [31:0] i_DBus_WriteData,
  output logic [31:0] o_DBus_ReadData,
  output logic        o_TimerIrq
);

  logic        sel;
  logic [2:0]  idx;
  logic        rd_en;
  logic        wr_en;
  logic [31:0] wmask;
  logic        wr_mtime;
  logic        wr_ctrl;
  logic        tick;
  logic [7:0]  ctrl_prescale;

  logic [63:0] mtime_q, mtime_d;
  logic [63:0] mtimecmp_q, mtimecmp_d;
  logic        en_q, en_d;
  logic        wrap_q, wrap_d;
  logic [31:0] rdata_q, rdata_d;
  logic        irq_q, irq_d;

  assign sel   = (i_DBus_Address[29:3] == p_BASE_ADDR[31:5]);
  assign idx   = i_DBus_Address[2:0];
  assign rd_en = sel & i_DBus_Read;
  // An all-zero byte enable is treated as no write at all.
  assign wr_en = sel & i_DBus_Write & (|i_DBus_ByteEn);
  assign wmask = {{8{i_DBus_ByteEn[3]}}, {8{i_DBus_ByteEn[2]}},
                  {8{i_DBus_ByteEn[1]}}, {8{i_DBus_ByteEn[0]}}};
  assign wr_mtime = wr_en & ((idx == 3'd0) | (idx == 3'd1));
  assign wr_ctrl  = wr_en & (idx == 3'd4);

`ifdef DBUS_MTIMER_PRESCALER_EN
  logic [7:0] prescale_q, prescale_d;
  logic [7:0] pcnt_q, pcnt_d;

  assign tick          = en_q & (pcnt_q == prescale_q);
  assign ctrl_prescale = prescale_q;

  // Prescale divider: count up while enabled, restart on tick or CTRL write.
  always_comb begin
    prescale_d = prescale_q;
    pcnt_d     = pcnt_q;
    if (wr_ctrl && i_DBus_ByteEn[1]) prescale_d = i_DBus_WriteData[15:8];
    if (wr_ctrl)   pcnt_d = 8'd0;
    else if (tick) pcnt_d = 8'd0;
    else if (en_q) pcnt_d = pcnt_q + 8'd1;
  end

  // Prescaler state registers.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      prescale_q <= p_PRESCALE_RESET;
      pcnt_q     <= 8'd0;
    end else begin
      prescale_q <= prescale_d;
      pcnt_q     <= pcnt_d;
    end
  end
`else
  assign tick = en_q;
  // The reset parameter has no effect without the divider; the AND keeps the
  // field at zero while still referencing the parameter.
  assign ctrl_prescale = p_PRESCALE_RESET & 8'h00;
`endif

  // Timer, control, status and read-data next-state logic.
  always_comb begin
    mtime_d    = mtime_q;
    mtimecmp_d = mtimecmp_q;
    en_d       = en_q;
    wrap_d     = wrap_q;
    rdata_d    = 32'h0;
    irq_d      = en_q & (mtime_q >= mtimecmp_q);

    // A software write to either MTIME half wins over the tick in that cycle.
    if (wr_mtime) begin
      if (idx == 3'd0) mtime_d[31:0]  = (mtime_q[31:0]  & ~wmask) | (i_DBus_WriteData & wmask);
      else             mtime_d[63:32] = (mtime_q[63:32] & ~wmask) | (i_DBus_WriteData & wmask);
    end else if (tick) begin
      mtime_d = mtime_q + 64'd1;
    end

    if (wr_en && idx == 3'd2) mtimecmp_d[31:0]  = (mtimecmp_q[31:0]  & ~wmask) | (i_DBus_WriteData & wmask);
    if (wr_en && idx == 3'd3) mtimecmp_d[63:32] = (mtimecmp_q[63:32] & ~wmask) | (i_DBus_WriteData & wmask);

    if (wr_ctrl && i_DBus_ByteEn[0]) en_d = i_DBus_WriteData[0];

    // WRAP: write-one-to-clear, but a wrap in the same cycle takes priority.
    if (wr_en && idx == 3'd5 && i_DBus_ByteEn[0] && i_DBus_WriteData[1]) wrap_d = 1'b0;
    if (tick && !wr_mtime && (&mtime_q)) wrap_d = 1'b1;

    // Reads see the register values from before this cycle's write.
    if (rd_en) begin
      case (idx)
        3'd0:    rdata_d = mtime_q[31:0];
        3'd1:    rdata_d = mtime_q[63:32];
        3'd2:    rdata_d = mtimecmp_q[31:0];
        3'd3:    rdata_d = mtimecmp_q[63:32];
        3'd4:    rdata_d = {16'h0, ctrl_prescale, 7'h0, en_q};
        3'd5:    rdata_d = {30'h0, wrap_q, irq_q};
        default: rdata_d = 32'h0;
      endcase
    end
  end

  // Main state registers.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      mtime_q    <= 64'h0;
      mtimecmp_q <= 64'hFFFF_FFFF_FFFF_FFFF;
      en_q       <= 1'b0;
      wrap_q     <= 1'b0;
      rdata_q    <= 32'h0;
      irq_q      <= 1'b0;
    end else begin
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      en_q       <= en_d;
      wrap_q     <= wrap_d;
      rdata_q    <= rdata_d;
      irq_q      <= irq_d;
    end
  end

  assign o_DBus_ReadData = rdata_q;
  assign o_TimerIrq      = irq_q;

endmodule

// File: tb/tb_dbus_mtimer_target.sv
// Testbench for dbus_mtimer_target: directed scenarios plus randomized bus
// traffic, checked against a behavioural timer model with an expected queue.
module tb_dbus_mtimer_target;

  localparam logic [31:0] BASE   = 32'h0200_0000;
  localparam logic [29:0] BASE_W = BASE[31:2];
  localparam logic [29:0] OFF_W  = BASE_W + 30'd16;   // base + 0x40, not selected

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [29:0] addr = '0;
  logic [3:0]  be = '0;
  logic        rd = 1'b0;
  logic        wr = 1'b0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        irq;

  always #5 clk = ~clk;

  dbus_mtimer_target #(.p_BASE_ADDR(BASE), .p_PRESCALE_RESET(8'd0)) dut (
    .i_Clk(clk), .i_Rst(rst), .i_DBus_Address(addr), .i_DBus_ByteEn(be),
    .i_DBus_Read(rd), .i_DBus_Write(wr), .i_DBus_WriteData(wdata),
    .o_DBus_ReadData(rdata), .o_TimerIrq(irq)
  );

  // ---------------- scoreboard state ----------------
  typedef struct { logic has; logic [31:0] val; } dir_t;
  logic [31:0] exp_q[$];
  dir_t        dir_q[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [63:0] m_mtime, m_cmp;
  logic        m_en, m_wrap, m_irq;
  logic [7:0]  m_pre, m_pcnt;
  bit          m_ready = 1'b0;
  bit          rd_seen = 1'b0;

  function automatic logic [31:0] lane_merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] b);
    logic [31:0] r;
    r = o;
    for (int k = 0; k < 4; k++) if (b[k]) r[k*8 +: 8] = n[k*8 +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_read(input logic [2:0] i);
    logic [7:0] pv;
`ifdef DBUS_MTIMER_PRESCALER_EN
    pv = m_pre;
`else
    pv = 8'h0;
`endif
    case (i)
      3'd0: return m_mtime[31:0];
      3'd1: return m_mtime[63:32];
      3'd2: return m_cmp[31:0];
      3'd3: return m_cmp[63:32];
      3'd4: return {16'h0, pv, 7'h0, m_en};
      3'd5: return {30'h0, m_wrap, m_irq};
      default: return 32'h0;
    endcase
  endfunction

  // Model advances on each edge from the bus inputs; it enqueues read results.
  always @(posedge clk) begin
    logic s, w, wm, tk, n_irq, n_wrap;
    logic [2:0] ix;
    logic [63:0] n_mtime;
    if (rst) begin
      m_mtime = 64'h0; m_cmp = '1; m_en = 1'b0; m_wrap = 1'b0; m_irq = 1'b0;
      m_pre = 8'd0; m_pcnt = 8'd0; rd_seen = 1'b0; m_ready = 1'b1;
    end else begin
      s  = (addr[29:3] == BASE[31:5]);
      ix = addr[2:0];
      w  = s && wr && (be != 4'b0);
      if (rd) begin
        exp_q.push_back(s ? m_read(ix) : 32'h0);
        rd_seen = 1'b1;
      end else rd_seen = 1'b0;
      n_irq = m_en && (m_mtime >= m_cmp);
`ifdef DBUS_MTIMER_PRESCALER_EN
      tk = m_en && (m_pcnt == m_pre);
      if (w && ix == 3'd4) m_pcnt = 8'd0;
      else if (m_en) m_pcnt = tk ? 8'd0 : m_pcnt + 8'd1;
      if (w && ix == 3'd4 && be[1]) m_pre = wdata[15:8];
`else
      tk = m_en;
`endif
      wm = w && (ix <= 3'd1);
      n_mtime = m_mtime;
      if (wm) begin
        if (ix == 3'd0) n_mtime[31:0]  = lane_merge(m_mtime[31:0], wdata, be);
        else            n_mtime[63:32] = lane_merge(m_mtime[63:32], wdata, be);
      end else if (tk) n_mtime = m_mtime + 64'd1;
      n_wrap = m_wrap;
      if (w && ix == 3'd5 && be[0] && wdata[1]) n_wrap = 1'b0;
      if (tk && !wm && m_mtime == 64'hFFFF_FFFF_FFFF_FFFF) n_wrap = 1'b1;
      if (w && ix == 3'd2) m_cmp[31:0]  = lane_merge(m_cmp[31:0], wdata, be);
      if (w && ix == 3'd3) m_cmp[63:32] = lane_merge(m_cmp[63:32], wdata, be);
      if (w && ix == 3'd4 && be[0]) m_en = wdata[0];
      m_mtime = n_mtime;
      m_wrap  = n_wrap;
      m_irq   = n_irq;
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [31:0] e;
    dir_t d;
    if (m_ready) begin
      if (rd_seen) begin
        if (exp_q.size() == 0 || dir_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL rd_queue_empty actual=empty expected=entry t=%0t", $time);
        end else begin
          e = exp_q.pop_front();
          d = dir_q.pop_front();
          check("rdata", rdata, e);
          if (d.has) check("rdata_directed", rdata, d.val);
        end
      end else begin
        check("rdata_idle", rdata, 32'h0);
      end
      check("irq", {31'h0, irq}, {31'h0, m_irq});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic bus(input logic r, input logic w, input logic [29:0] a, input logic [3:0] b,
                     input logic [31:0] d, input logic hd, input logic [31:0] dv);
    rd = r; wr = w; addr = a; be = b; wdata = d;
    if (r && !rst) dir_q.push_back('{hd, dv});
    @(posedge clk); #1;
    rd = 1'b0; wr = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) bus(1'b0, 1'b0, BASE_W, 4'h0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic wr_reg(input logic [2:0] i, input logic [3:0] b, input logic [31:0] d);
    bus(1'b0, 1'b1, BASE_W + {27'h0, i}, b, d, 1'b0, 32'h0);
  endtask

  task automatic rd_chk(input logic [2:0] i, input logic [31:0] v);
    bus(1'b1, 1'b0, BASE_W + {27'h0, i}, 4'h0, 32'h0, 1'b1, v);
  endtask

  task automatic do_reset();
    rst = 1'b1; idle(2); rst = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [29:0] a;
    logic [31:0] d;
    logic        r, w;
    #1;
    do_reset();
    // Reset values.
    rd_chk(3'd4, 32'h0);
    rd_chk(3'd3, 32'hFFFF_FFFF);
    rd_chk(3'd7, 32'h0);
    // Single byte-lane write.
    wr_reg(3'd2, 4'b0100, 32'hAABB_CCDD);
    rd_chk(3'd2, 32'hFFBB_FFFF);

    // Counting and interrupt.
    do_reset();
    wr_reg(3'd2, 4'hF, 32'd5);
    wr_reg(3'd3, 4'hF, 32'd0);
    wr_reg(3'd4, 4'hF, 32'h1);
    idle(10);
    rd_chk(3'd0, 32'd10);
    // Unselected address: read zero, no state change.
    bus(1'b0, 1'b1, OFF_W + 30'd2, 4'hF, 32'h0, 1'b0, 32'h0);
    bus(1'b1, 1'b0, OFF_W + 30'd2, 4'h0, 32'h0, 1'b1, 32'h0);
    rd_chk(3'd2, 32'd5);

    // 64-bit wrap and W1C.
    do_reset();
    wr_reg(3'd0, 4'hF, 32'hFFFF_FFFE);
    wr_reg(3'd1, 4'hF, 32'hFFFF_FFFF);
    wr_reg(3'd4, 4'hF, 32'h1);
    idle(3);
    rd_chk(3'd5, 32'h2);
    wr_reg(3'd5, 4'hF, 32'h2);
    rd_chk(3'd5, 32'h0);

    // Prescaler.
    do_reset();
    wr_reg(3'd4, 4'hF, 32'h0301);
    idle(8);
`ifdef DBUS_MTIMER_PRESCALER_EN
    rd_chk(3'd0, 32'd2);
    rd_chk(3'd4, 32'h0301);
`else
    rd_chk(3'd0, 32'd8);
    rd_chk(3'd4, 32'h0001);
`endif

    // Randomized traffic.
    for (int n = 0; n < 800; n++) begin
      a = ($urandom_range(0, 7) == 0) ? OFF_W + 30'($urandom_range(0, 7))
                                      : BASE_W + 30'($urandom_range(0, 7));
      d = $urandom;
      case ($urandom_range(0, 3))
        0: d = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
        1: d = {16'h0, 8'($urandom_range(0, 3)), 7'h0, 1'($urandom_range(0, 1))};
        default: ;
      endcase
      r = 1'($urandom_range(0, 1));
      w = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 99) == 0) begin
        rst = 1'b1;
        bus(r, w, a, 4'($urandom), d, 1'b0, 32'h0);
        rst = 1'b0;
      end else begin
        bus(r, w, a, 4'($urandom), d, 1'b0, 32'h0);
      end
    end

    idle(3);
    check("exp_q_drained", 32'(exp_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
